// File: rtl/ofdm_cp_serializer_pkg.sv
// Shared types for the OFDM transmit path: complex sample, serializer FSM state, defaults.
package ofdm_cp_serializer_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned OFDM_N      = 8;
  localparam int unsigned OFDM_CP_LEN = 2;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] r;
    logic signed [SAMPLE_W-1:0] i;
  } complex_product_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } cp_state_e;

  // Occupancy update for the two-slot buffer; capture and free together leave it unchanged.
  function automatic logic [1:0] count_update(input logic [1:0] c,
                                              input logic       inc,
                                              input logic       dec);
    logic [1:0] res;
    res = c;
    case ({inc, dec})
      2'b10:   res = c + 2'd1;
      2'b01:   res = c - 2'd1;
      default: res = c;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ofdm_cp_serializer_buffer.sv
// Two-slot frame store: whole-frame write port, combinational sample/mode read mux.
module cp_frame_buffer
  import ofdm_cp_serializer_pkg::*;
#(
  parameter  int unsigned N     = OFDM_N,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  complex_product_t [N-1:0]  wr_frame,
  input  logic                      wr_mode,
  input  logic                      rd_sel,
  input  logic [IDX_W-1:0]          rd_idx,
  output complex_product_t          rd_data_c,
  output logic                      rd_mode_c
);

  complex_product_t [N-1:0] slot_q [2];
  logic [1:0]               mode_q;

  // Store an accepted frame and its stream id; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_q[wr_sel] <= wr_frame;
      mode_q[wr_sel] <= wr_mode;
    end
  end

  assign rd_data_c = slot_q[rd_sel][rd_idx];
  assign rd_mode_c = mode_q[rd_sel];

endmodule

// File: rtl/ofdm_cp_serializer.sv
// Parallel-to-serial OFDM symbol emitter with cyclic prefix and ping-pong frame buffering.
module ofdm_cp_serializer
  import ofdm_cp_serializer_pkg::*;
#(
  parameter int unsigned N      = OFDM_N,
  parameter int unsigned CP_LEN = OFDM_CP_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  complex_product_t [N-1:0]  frame_in,
  input  logic                      in_valid,
  input  logic                      in_mode,
  output logic                      in_ready,
  output complex_product_t          data_out,
  output logic                      out_valid,
  output logic                      out_mode,
  output logic                      sof,
  output logic                      eof,
  input  logic                      out_ready
);

  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned CP_LAST = (CP_LEN > 0) ? CP_LEN - 1 : 0;
  localparam int unsigned CP_BASE = N - CP_LEN;

  cp_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       count_q, count_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic             valid_d, sof_d, eof_d;
  logic             load, start_frame;
  logic             capture, transfer, frame_done;
  logic [IDX_W-1:0] rd_idx;
  complex_product_t buf_data_c, sample_c;
  logic             buf_mode_c, sample_mode_c;

  assign in_ready   = (count_q < 2'd2) && !reset;
  assign capture    = enable && in_valid && in_ready;
  assign transfer   = enable && out_valid && out_ready;
  assign frame_done = transfer && (state_q == BODY) && (idx_q == IDX_W'(N - 1));

  cp_frame_buffer #(.N(N)) u_buf (
    .clk       (clk),
    .wr_en     (capture),
    .wr_sel    (wr_sel_q),
    .wr_frame  (frame_in),
    .wr_mode   (in_mode),
    .rd_sel    (rd_sel_d),
    .rd_idx    (rd_idx),
    .rd_data_c (buf_data_c),
    .rd_mode_c (buf_mode_c)
  );

  // Address of the sample to present next: prefix reads the frame tail, body reads from 0.
  assign rd_idx = (state_d == CP) ? IDX_W'(CP_BASE) + idx_d : idx_d;

  // A frame landing in the slot we are about to read (refill on the last body transfer) is
  // taken straight from the input so the next symbol follows without a gap.
  assign sample_c      = (capture && (wr_sel_q == rd_sel_d)) ? frame_in[rd_idx] : buf_data_c;
  assign sample_mode_c = (capture && (wr_sel_q == rd_sel_d)) ? in_mode : buf_mode_c;

  // Next-state, pointer and output-flag logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_sel_d    = rd_sel_q;
    wr_sel_d    = wr_sel_q ^ capture;
    count_d     = count_update(count_q, capture, frame_done);
    valid_d     = out_valid;
    sof_d       = sof;
    eof_d       = eof;
    load        = 1'b0;
    start_frame = 1'b0;

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (count_q != 2'd0) start_frame = 1'b1;
        end
        CP: begin
          if (transfer) begin
            load = 1'b1;
            if (idx_q == IDX_W'(CP_LAST)) begin
              state_d = BODY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        BODY: begin
          if (frame_done) begin
            rd_sel_d = ~rd_sel_q;
            if (count_d != 2'd0) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              sof_d   = 1'b0;
              eof_d   = 1'b0;
            end
          end else if (transfer) begin
            load  = 1'b1;
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_frame) begin
        state_d = (CP_LEN > 0) ? CP : BODY;
        idx_d   = '0;
        load    = 1'b1;
      end

      if (load) begin
        valid_d = 1'b1;
        sof_d   = start_frame;
        eof_d   = (state_d == BODY) && (idx_d == IDX_W'(N - 1));
      end
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      out_mode  <= 1'b0;
      data_out  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      out_valid <= valid_d;
      sof       <= sof_d;
      eof       <= eof_d;
      if (load) begin
        data_out <= sample_c;
        out_mode <= sample_mode_c;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// Self-checking bench for ofdm_cp_serializer (N=8, CP_LEN=2, plus a CP_LEN=0 instance).
module tb_ofdm_cp_serializer;
  import ofdm_cp_serializer_pkg::*;

  localparam int N   = 8;
  localparam int CPL = 2;

  logic clk = 1'b0;
  logic reset, enable, in_valid, in_mode, in_ready, out_ready;
  logic out_valid, out_mode, sof, eof;
  complex_product_t [N-1:0] frame_in;
  complex_product_t data_out;
  logic in_valid0, in_ready0, out_valid0, out_mode0, sof0, eof0;
  complex_product_t data_out0;

  ofdm_cp_serializer #(.N(N), .CP_LEN(CPL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
    .in_valid(in_valid), .in_mode(in_mode), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_mode(out_mode),
    .sof(sof), .eof(eof), .out_ready(out_ready)
  );

  ofdm_cp_serializer #(.N(N), .CP_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .frame_in(frame_in),
    .in_valid(in_valid0), .in_mode(1'b0), .in_ready(in_ready0),
    .data_out(data_out0), .out_valid(out_valid0), .out_mode(out_mode0),
    .sof(sof0), .eof(eof0), .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] r;
    logic signed [15:0] i;
    bit mode;
    bit sof;
    bit eof;
  } exp_t;

  typedef struct {
    bit mode;
    int base;
    int stall_at;
    int exp_xfers;
    int exp_sof_r;
    int exp_eof_r;
  } vec_t;

  exp_t sb[$];
  int cycle = 0;
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int last_eof_edge = -100;
  logic signed [15:0] last_sof_r, last_eof_r;

  always @(posedge clk) cycle = cycle + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard: every transfer pops one expected sample.
  always @(negedge clk) begin
    if (!reset && enable && out_valid && out_ready) begin : mon
      exp_t e;
      xfers++;
      if (sof) last_sof_r = data_out.r;
      if (eof) begin
        last_eof_r    = data_out.r;
        last_eof_edge = cycle + 1;
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got r=%0d with nothing expected (cycle %0d)", data_out.r, cycle);
      end else begin
        e = sb.pop_front();
        if (data_out.r !== e.r || data_out.i !== e.i || out_mode !== e.mode ||
            sof !== e.sof || eof !== e.eof) begin
          errors++;
          $display("FAIL sample: got r=%0d i=%0d mode=%0d sof=%0d eof=%0d expected r=%0d i=%0d mode=%0d sof=%0d eof=%0d",
                   data_out.r, data_out.i, out_mode, sof, eof, e.r, e.i, e.mode, e.sof, e.eof);
        end
      end
    end
  end

  task automatic drive_frame(input int base);
    for (int k = 0; k < N; k++) begin
      frame_in[k].r = 16'(base + k);
      frame_in[k].i = 16'(-(base + k));
    end
  endtask

  task automatic push_frame(input bit mode, input int base);
    exp_t e;
    for (int j = 0; j < CPL; j++) begin
      e.r = 16'(base + N - CPL + j); e.i = 16'(-(base + N - CPL + j));
      e.mode = mode; e.sof = (j == 0); e.eof = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < N; k++) begin
      e.r = 16'(base + k); e.i = 16'(-(base + k));
      e.mode = mode; e.sof = (CPL == 0) && (k == 0); e.eof = (k == N - 1);
      sb.push_back(e);
    end
  endtask

  // Offer a frame until accepted; called and returns at posedge+1.
  task automatic send_frame(input bit mode, input int base, output int cap_edge);
    drive_frame(base);
    in_mode  = mode;
    in_valid = 1'b1;
    cap_edge = -1;
    for (int c = 0; c < 60; c++) begin
      if (in_ready && enable) begin
        cap_edge = cycle + 1;
        push_frame(mode, base);
        break;
      end
      @(posedge clk); #1;
    end
    if (cap_edge < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: frame base=%0d never accepted", base);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_sample(input int r, input bit need_eof, input string name);
    int n;
    n = 0;
    while (!(out_valid && data_out.r == 16'(r) && (!need_eof || eof)) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL %s: sample r=%0d never presented", name, r);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: not drained, %0d samples still expected", name, sb.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t v;
    int cap_a, cap_b, cap_c, n, x0;
    bit stalled;

    vecs[0] = '{0, 0, -1, 10, 6, 7};
    vecs[1] = '{1, 100, -1, 10, 106, 107};
    vecs[2] = '{0, 0, 3, 10, 6, 7};
    vecs[3] = '{1, -50, 5, 10, -44, -43};

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0;
    in_mode = 1'b0; out_ready = 1'b1;
    drive_frame(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sof", sof, 0);
    chk("rst_eof", eof, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table-driven single symbols, with optional backpressure on one body sample.
    for (int t = 0; t < 4; t++) begin
      v  = vecs[t];
      x0 = xfers;
      send_frame(v.mode, v.base, cap_a);
      chk("latency_idle", out_valid, 0);
      @(posedge clk); #1;
      chk("latency_first", {out_valid, sof}, 3);
      stalled = 1'b0;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 80) begin
        if (v.stall_at >= 0 && !stalled && out_valid && !sof &&
            data_out.r == 16'(v.base + v.stall_at)) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("stall_hold", data_out.r, 16'(v.base + v.stall_at));
          end
          out_ready = 1'b1;
        end
        @(posedge clk); #1; n++;
      end
      if (n >= 80) begin
        checks++; errors++;
        $display("FAIL vec_drain: vector %0d did not complete", t);
      end
      chk("vec_xfers", xfers - x0, v.exp_xfers);
      chk("vec_sof_r", last_sof_r, v.exp_sof_r);
      chk("vec_eof_r", last_eof_r, v.exp_eof_r);
    end

    // Back-to-back frames of different streams.
    send_frame(0, 0, cap_a);
    send_frame(1, 100, cap_b);
    chk("b2b_capture_gap", cap_b - cap_a, 1);
    chk("b2b_in_ready_full", in_ready, 0);
    n = 0;
    while (out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_contiguous", n, 20);
    chk("b2b_in_ready_after", in_ready, 1);
    drain(20, "b2b_drain");

    // Full buffer: third frame waits for the first eof transfer.
    out_ready = 1'b0;
    send_frame(0, 200, cap_a);
    send_frame(1, 300, cap_b);
    chk("full_in_ready", in_ready, 0);
    drive_frame(400); in_mode = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_hold_off", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_frame(0, 400, cap_c);
    chk("full_accept_edge", cap_c, last_eof_edge + 1);
    drain(80, "full_drain");

    // Capture on the same edge as the last body transfer: next symbol without a gap.
    send_frame(0, 500, cap_a);
    wait_sample(507, 1'b1, "simul_wait_eof");
    drive_frame(600); in_mode = 1'b1;
    chk("simul_in_ready", in_ready, 1);
    in_valid = 1'b1;
    push_frame(1, 600);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("simul_no_gap", {out_valid, sof}, 3);
    chk("simul_mode", out_mode, 1);
    drain(40, "simul_drain");

    // enable low mid-symbol: outputs frozen, no capture, resume at same index.
    send_frame(0, 700, cap_a);
    wait_sample(702, 1'b0, "freeze_wait");
    enable = 1'b0;
    drive_frame(800); in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("freeze_r", data_out.r, 702);
      chk("freeze_valid", out_valid, 1);
      chk("freeze_sof_eof", {sof, eof}, 0);
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    drain(40, "freeze_drain");

    // Reset mid-symbol with both slots full.
    send_frame(1, 900, cap_a);
    send_frame(0, 1000, cap_b);
    wait_sample(904, 1'b0, "rst_wait");
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready_hold", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("midrst_count_zero", in_ready, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_stays_idle", out_valid, 0);

    // CP_LEN = 0 instance: body only, sof on the first body sample.
    drive_frame(0);
    chk("cp0_in_ready", in_ready0, 1);
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      chk("cp0_valid", out_valid0, 1);
      chk("cp0_r", data_out0.r, k);
      chk("cp0_sof_eof", {sof0, eof0}, {k == 0, k == N - 1});
      @(posedge clk); #1;
    end
    chk("cp0_done", out_valid0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
